cpu_bus_responder: RTL

CPU_BUS_RESPONDER -- requirements
Module: cpu_bus_responder

---
 rtl/cpu_bus_responder_pkg.sv | 24 ++
 rtl/cpu_bus_responder_if.sv | 38 +++
 rtl/cpu_bus_responder_bus_ram.sv | 28 ++
 rtl/cpu_bus_responder.sv | 108 ++++++++++
 4 files changed

// File: rtl/cpu_bus_responder_pkg.sv
// Shared definitions for the CPU bus responder: FSM encodings, I/O window
// defaults and the read value returned by an abandoned I/O access.
package cpu_bus_responder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        IO_REQ  = 2'b01,
        IO_DONE = 2'b10
    } state_t;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 8;
    localparam int IO_ADDR_W = 12;
    localparam int CNT_W     = 8;

    localparam logic [3:0]        IO_PAGE_DEF     = 4'hD;
    localparam logic [CNT_W-1:0]  IO_TIMEOUT_DEF  = 8'd31;
    localparam logic [DATA_W-1:0] IO_TIMEOUT_DATA = 8'hFF;

    function automatic logic page_hit(input logic [ADDR_W-1:0] addr, input logic [3:0] page);
        return addr[ADDR_W-1:ADDR_W-4] == page;
    endfunction

endpackage

// File: rtl/cpu_bus_responder_if.sv
// CPU-side and I/O-side bus signals of the responder, bundled with
// modports for the responder (slave) and the CPU/peripheral side (master).
interface cpu_bus_responder_if;
    import cpu_bus_responder_pkg::*;

    logic [ADDR_W-1:0]    address_next;
    logic                 write_next;
    logic [DATA_W-1:0]    data_o_next;
    logic [ADDR_W-1:0]    address;
    logic                 write;
    logic [DATA_W-1:0]    data_o;
    logic                 ready;
    logic [DATA_W-1:0]    data_i;
    logic                 io_req;
    logic                 io_we;
    logic [IO_ADDR_W-1:0] io_addr;
    logic [DATA_W-1:0]    io_wdata;
    logic                 io_ack;
    logic [DATA_W-1:0]    io_rdata;
    logic                 io_timeout;

    modport slave (
        input  address_next, write_next, data_o_next,
        input  address, write, data_o,
        input  io_ack, io_rdata,
        output ready, data_i,
        output io_req, io_we, io_addr, io_wdata, io_timeout
    );

    modport master (
        output address_next, write_next, data_o_next,
        output address, write, data_o,
        output io_ack, io_rdata,
        input  ready, data_i,
        input  io_req, io_we, io_addr, io_wdata, io_timeout
    );

endinterface

// File: rtl/cpu_bus_responder_bus_ram.sv
// 64Kx8 synchronous RAM: registered read address, write-first when the
// write and the read target the same location on the same edge.
module bus_ram
    import cpu_bus_responder_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // No reset: contents survive a responder reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (we && (waddr == raddr)) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/cpu_bus_responder.sv
// Zero-wait-state RAM responder for a CPU bus with one 4 KB I/O window that
// is forwarded to a handshake port with an acknowledge timeout.
//
// state   | meaning
// IDLE    | RAM accesses complete immediately; an I/O hit starts a request
// IO_REQ  | io_req held, waiting for io_ack or the timeout count
// IO_DONE | captured I/O data presented with ready=1 for one cycle
module cpu_bus_responder
    import cpu_bus_responder_pkg::*;
#(
    parameter logic [3:0]       IO_PAGE    = IO_PAGE_DEF,
    parameter logic [CNT_W-1:0] IO_TIMEOUT = IO_TIMEOUT_DEF
) (
    input logic                clk,
    input logic                reset,
    cpu_bus_responder_if.slave bus
);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [DATA_W-1:0] rd_reg, rd_next;
    logic              timeout_q, timeout_next;
    logic              io_req_q;
    logic              io_hit;
    logic              ready_c;
    logic [DATA_W-1:0] data_c;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;
    logic              unused_next;

    assign io_hit      = page_hit(bus.address, IO_PAGE);
    assign ram_we      = ready_c & bus.write & ~io_hit;
    assign unused_next = ^{bus.write_next, bus.data_o_next};

    bus_ram u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (bus.address),
        .wdata (bus.data_o),
        .raddr (bus.address_next),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        rd_next      = rd_reg;
        timeout_next = 1'b0;
        ready_c      = 1'b0;
        data_c       = rd_reg;
        case (state)
            IDLE: begin
                ready_c = ~io_hit;
                data_c  = ram_rdata;
                if (io_hit) begin
                    state_next = IO_REQ;
                    cnt_next   = '0;
                end
            end
            IO_REQ: begin
                // An acknowledge on the terminal-count cycle still wins.
                if (bus.io_ack) begin
                    rd_next    = bus.io_rdata;
                    state_next = IO_DONE;
                end else if (cnt == IO_TIMEOUT) begin
                    rd_next      = IO_TIMEOUT_DATA;
                    timeout_next = 1'b1;
                    state_next   = IO_DONE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            IO_DONE: begin
                ready_c    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rd_reg    <= '0;
            timeout_q <= 1'b0;
            io_req_q  <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            rd_reg    <= rd_next;
            timeout_q <= timeout_next;
            io_req_q  <= (state_next == IO_REQ);
        end
    end

    // io_req comes straight from a flop so the peripheral never sees a glitch.
    assign bus.ready      = ready_c;
    assign bus.data_i     = data_c;
    assign bus.io_req     = io_req_q;
    assign bus.io_we      = io_req_q & bus.write;
    assign bus.io_addr    = bus.address[IO_ADDR_W-1:0];
    assign bus.io_wdata   = bus.data_o;
    assign bus.io_timeout = timeout_q;

endmodule
